// File: rtl/zork_pkg.sv
// -----------------------------------------------------------------------------
// zork_pkg
// Shared definitions for the grid-game player logic:
//   - dir_e        : internal move direction codes
//   - KEY_*        : keypad codes produced by the keypad decoder
//   - nav_state_e  : player_nav_ctrl FSM state encoding
//   - key_to_dir() : keypad code -> direction (unknown codes map to DIR_NONE)
// -----------------------------------------------------------------------------
package zork_pkg;

    typedef enum logic [2:0] {
        DIR_UP    = 3'b000,
        DIR_DOWN  = 3'b001,
        DIR_RIGHT = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_NONE  = 3'b100
    } dir_e;

    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_DOWN  = 4'h8;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_EVAL   = 2'b10,
        ST_HOLD   = 2'b11
    } nav_state_e;

    function automatic dir_e key_to_dir(input logic [3:0] key);
        case (key)
            KEY_UP:    return DIR_UP;
            KEY_DOWN:  return DIR_DOWN;
            KEY_LEFT:  return DIR_LEFT;
            KEY_RIGHT: return DIR_RIGHT;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/nav_next_cell.sv
// -----------------------------------------------------------------------------
// nav_next_cell
// Combinational neighbour calculation: the cell one step from (pos_x, pos_y)
// in direction dir, with edge handling.
// Ports:
//   pos_x_i, pos_y_i   in   current position
//   dir_i              in   requested direction (DIR_NONE -> candidate = pos)
//   cand_x_o, cand_y_o out  candidate cell, always inside the grid
//   off_grid_o         out  1 when the step leaves the grid and WRAP=0
// -----------------------------------------------------------------------------
module nav_next_cell
    import zork_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter bit WRAP   = 1'b0,
    localparam int XW    = $clog2(GRID_W),
    localparam int YW    = $clog2(GRID_H)
) (
    input  logic [XW-1:0] pos_x_i,
    input  logic [YW-1:0] pos_y_i,
    input  dir_e          dir_i,
    output logic [XW-1:0] cand_x_o,
    output logic [YW-1:0] cand_y_o,
    output logic          off_grid_o
);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

    // Edges are compared against GRID_x-1 rather than relying on counter
    // overflow, so grids that are not a power of two never yield x>=GRID_W.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case can leave one unassigned and infer a latch.
        cand_x_o   = pos_x_i;
        cand_y_o   = pos_y_i;
        off_grid_o = 1'b0;
        case (dir_i)
            DIR_UP: begin
                if (pos_y_i == '0) begin
                    off_grid_o = !WRAP;
                    cand_y_o   = WRAP ? Y_MAX : pos_y_i;
                end else begin
                    cand_y_o = pos_y_i - Y_ONE;
                end
            end
            DIR_DOWN: begin
                if (pos_y_i == Y_MAX) begin
                    off_grid_o = !WRAP;
                    cand_y_o   = WRAP ? '0 : pos_y_i;
                end else begin
                    cand_y_o = pos_y_i + Y_ONE;
                end
            end
            DIR_LEFT: begin
                if (pos_x_i == '0) begin
                    off_grid_o = !WRAP;
                    cand_x_o   = WRAP ? X_MAX : pos_x_i;
                end else begin
                    cand_x_o = pos_x_i - X_ONE;
                end
            end
            DIR_RIGHT: begin
                if (pos_x_i == X_MAX) begin
                    off_grid_o = !WRAP;
                    cand_x_o   = WRAP ? '0 : pos_x_i;
                end else begin
                    cand_x_o = pos_x_i + X_ONE;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/player_nav_ctrl.sv
// -----------------------------------------------------------------------------
// player_nav_ctrl
// Turns keypad codes into one-cell player moves on a GRID_W x GRID_H grid,
// checking a wall map before each move, with optional wrap-around and
// auto-repeat while the key is held. Keeps a saturating count of moves.
// Ports:
//   clk_50MHz_i     in   system clock
//   rst_async_la_i  in   asynchronous active-low reset
//   key_in          in   keypad code (2 up, 8 down, 4 left, 6 right)
//   enable_move     in   key-valid level, asynchronous (synchronised here)
//   map_rd_o        out  wall-map read strobe
//   map_addr_o      out  candidate cell {x, y}; holds last candidate
//   map_blocked_i   in   wall bit, valid the cycle after map_rd_o
//   address         out  current position {posx, posy}
//   moved_o         out  pulse on the first cycle of a new address
//   bump_o          out  pulse when a move is rejected
//   move_count_o    out  successful moves, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module player_nav_ctrl
    import zork_pkg::*;
#(
    parameter int          GRID_W        = 16,
    parameter int          GRID_H        = 16,
    parameter int          START_X       = 7,
    parameter int          START_Y       = 7,
    parameter bit          WRAP          = 1'b0,
    parameter int          REPEAT_CYCLES = 0,
    // Reset value of move_count_o; 0 for normal use.
    parameter logic [15:0] COUNT_INIT    = 16'h0000,
    localparam int         XW            = $clog2(GRID_W),
    localparam int         YW            = $clog2(GRID_H)
) (
    input  logic             clk_50MHz_i,
    input  logic             rst_async_la_i,
    input  logic [3:0]       key_in,
    input  logic             enable_move,
    output logic             map_rd_o,
    output logic [XW+YW-1:0] map_addr_o,
    input  logic             map_blocked_i,
    output logic [XW+YW-1:0] address,
    output logic             moved_o,
    output logic             bump_o,
    output logic [15:0]      move_count_o
);

    // Timer only needs to reach max(REPEAT_CYCLES, 3); the +4 keeps headroom.
    localparam int          TW        = $clog2(REPEAT_CYCLES + 4);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] REP_T     = TW'(REPEAT_CYCLES);

    logic             sync1_q, sync1_d, sync2_q, sync2_d, en_prev_q, en_prev_d;
    nav_state_e       state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [XW-1:0]    pos_x_q, pos_x_d, cand_x_q, cand_x_d;
    logic [YW-1:0]    pos_y_q, pos_y_d, cand_y_q, cand_y_d;
    logic [15:0]      count_q, count_d;
    logic             moved_q, moved_d, bump_q, bump_d, map_rd_q, map_rd_d;
    logic [TW-1:0]    timer_q, timer_d;

    dir_e             key_dir, nav_dir;
    logic [XW-1:0]    nxt_x;
    logic [YW-1:0]    nxt_y;
    logic             nxt_off, rise, launch;

    assign key_dir = key_to_dir(key_in);
    // A fresh press uses the live key; auto-repeat reuses the latched one.
    assign nav_dir = (state_q == ST_IDLE) ? key_dir : dir_q;
    assign rise    = sync2_q & ~en_prev_q;

    nav_next_cell #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .WRAP   (WRAP)
    ) u_next (
        .pos_x_i    (pos_x_q),
        .pos_y_i    (pos_y_q),
        .dir_i      (nav_dir),
        .cand_x_o   (nxt_x),
        .cand_y_o   (nxt_y),
        .off_grid_o (nxt_off)
    );

    always_comb begin
        sync1_d   = enable_move;
        sync2_d   = sync1_q;
        en_prev_d = sync2_q;
        state_d   = state_q;
        dir_d     = dir_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        count_d   = count_q;
        moved_d   = 1'b0;
        bump_d    = 1'b0;
        map_rd_d  = 1'b0;
        timer_d   = (timer_q == '1) ? timer_q : timer_q + TIMER_ONE;
        launch    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise && key_dir != DIR_NONE) begin
                    dir_d  = key_dir;
                    launch = 1'b1;
                end
            end
            ST_LOOKUP: state_d = ST_EVAL;
            ST_EVAL: begin
                if (map_blocked_i) begin
                    bump_d = 1'b1;
                end else begin
                    pos_x_d = cand_x_q;
                    pos_y_d = cand_y_q;
                    moved_d = 1'b1;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Release wins over a repeat due in the same cycle.
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_CYCLES > 0 && timer_q >= REP_T) begin
                    launch = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The timer counts clocks since the launch of the current move, so the
        // lookup/eval cycles are part of the repeat period and repeat moves are
        // exactly REPEAT_CYCLES apart.
        if (launch) begin
            timer_d = TIMER_ONE;
            if (nxt_off) begin
                bump_d  = 1'b1;
                state_d = ST_HOLD;
            end else begin
                cand_x_d = nxt_x;
                cand_y_d = nxt_y;
                map_rd_d = 1'b1;
                state_d  = ST_LOOKUP;
            end
        end
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            en_prev_q <= 1'b0;
            state_q   <= ST_IDLE;
            dir_q     <= DIR_NONE;
            pos_x_q   <= XW'(START_X);
            pos_y_q   <= YW'(START_Y);
            cand_x_q  <= XW'(START_X);
            cand_y_q  <= YW'(START_Y);
            count_q   <= COUNT_INIT;
            moved_q   <= 1'b0;
            bump_q    <= 1'b0;
            map_rd_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            en_prev_q <= en_prev_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            count_q   <= count_d;
            moved_q   <= moved_d;
            bump_q    <= bump_d;
            map_rd_q  <= map_rd_d;
            timer_q   <= timer_d;
        end
    end

    assign map_rd_o     = map_rd_q;
    assign map_addr_o   = {cand_x_q, cand_y_q};
    assign address      = {pos_x_q, pos_y_q};
    assign moved_o      = moved_q;
    assign bump_o       = bump_q;
    assign move_count_o = count_q;

endmodule

// File: tb/tb_player_nav_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_nav_ctrl
// Four player_nav_ctrl instances share key/enable stimulus:
//   0: defaults, 1: WRAP=1, 2: REPEAT_CYCLES=10 with count preset 16'hFFFE,
//   3: 10x12 grid with WRAP=1.
// A shared wall map answers each instance's reads one cycle later. A grid
// model (plain integer coordinates, modulo wrap) predicts each press.
// -----------------------------------------------------------------------------
module tb_player_nav_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic             rst_n;
    logic [3:0]       key;
    logic             en;
    logic [3:0]       map_rd, moved, bump, blk;
    logic [3:0][7:0]  map_addr, addr;
    logic [3:0][15:0] cnt;
    bit               walls [256];

    int total = 0;
    int bad   = 0;

    int cfg_w    [4] = '{16, 16, 16, 10};
    int cfg_h    [4] = '{16, 16, 16, 12};
    int cfg_wrap [4] = '{0, 1, 0, 1};
    int cfg_init [4] = '{0, 0, 65534, 0};

    player_nav_ctrl u_dut0 (
        .clk_50MHz_i(clk), .rst_async_la_i(rst_n), .key_in(key), .enable_move(en),
        .map_rd_o(map_rd[0]), .map_addr_o(map_addr[0]), .map_blocked_i(blk[0]),
        .address(addr[0]), .moved_o(moved[0]), .bump_o(bump[0]), .move_count_o(cnt[0]));

    player_nav_ctrl #(.WRAP(1'b1)) u_dut1 (
        .clk_50MHz_i(clk), .rst_async_la_i(rst_n), .key_in(key), .enable_move(en),
        .map_rd_o(map_rd[1]), .map_addr_o(map_addr[1]), .map_blocked_i(blk[1]),
        .address(addr[1]), .moved_o(moved[1]), .bump_o(bump[1]), .move_count_o(cnt[1]));

    player_nav_ctrl #(.REPEAT_CYCLES(10), .COUNT_INIT(16'hFFFE)) u_dut2 (
        .clk_50MHz_i(clk), .rst_async_la_i(rst_n), .key_in(key), .enable_move(en),
        .map_rd_o(map_rd[2]), .map_addr_o(map_addr[2]), .map_blocked_i(blk[2]),
        .address(addr[2]), .moved_o(moved[2]), .bump_o(bump[2]), .move_count_o(cnt[2]));

    player_nav_ctrl #(.GRID_W(10), .GRID_H(12), .WRAP(1'b1)) u_dut3 (
        .clk_50MHz_i(clk), .rst_async_la_i(rst_n), .key_in(key), .enable_move(en),
        .map_rd_o(map_rd[3]), .map_addr_o(map_addr[3]), .map_blocked_i(blk[3]),
        .address(addr[3]), .moved_o(moved[3]), .bump_o(bump[3]), .move_count_o(cnt[3]));

    // Wall-map RAM: data for the address seen at one edge appears after it.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) blk[i] <= walls[map_addr[i]];
    end

    // Pulse monitors.
    int n_mv [4];
    int n_bp [4];
    int n_rd [4];
    int n_both  = 0;
    int n_range = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (moved[i] === 1'b1) n_mv[i]++;
            if (bump[i] === 1'b1) n_bp[i]++;
            if (map_rd[i] === 1'b1) n_rd[i]++;
            if (moved[i] === 1'b1 && bump[i] === 1'b1) n_both++;
        end
        if (addr[3][7:4] >= 4'd10 || addr[3][3:0] >= 4'd12) n_range++;
    end

    // ---------------- reference model ----------------
    int ex [4];
    int ey [4];
    int ecnt [4];
    int e_mv [4];
    int e_bp [4];
    int e_rd [4];

    function automatic int key_dir(input logic [3:0] k);
        case (k)
            4'h2:    return 0;
            4'h8:    return 1;
            4'h6:    return 2;
            4'h4:    return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ex[i] = 7; ey[i] = 7; ecnt[i] = cfg_init[i];
        end
    endtask

    task automatic model_attempt(input int i, input int d);
        int nx, ny;
        bit off;
        nx = ex[i]; ny = ey[i]; off = 1'b0;
        case (d)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx + 1;
            default: nx = nx - 1;
        endcase
        if (nx < 0 || nx >= cfg_w[i] || ny < 0 || ny >= cfg_h[i]) begin
            off = 1'b1;
            nx = (nx + cfg_w[i]) % cfg_w[i];
            ny = (ny + cfg_h[i]) % cfg_h[i];
        end
        if (off && cfg_wrap[i] == 0) begin
            e_bp[i]++;
        end else begin
            e_rd[i]++;
            if (walls[nx * 16 + ny]) begin
                e_bp[i]++;
            end else begin
                ex[i] = nx; ey[i] = ny; e_mv[i]++;
                if (ecnt[i] < 65535) ecnt[i]++;
            end
        end
    endtask

    task automatic clear_walls();
        for (int a = 0; a < 256; a++) walls[a] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; key = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_a = 8'h77;
            total++;
            if (addr[i] !== exp_a) begin
                bad++; $display("FAIL reset_addr dut%0d got %h want %h", i, addr[i], exp_a);
            end
            total++;
            if (cnt[i] !== 16'(cfg_init[i])) begin
                bad++; $display("FAIL reset_count dut%0d got %h want %h", i, cnt[i], 16'(cfg_init[i]));
            end
            total++;
            if ({moved[i], bump[i], map_rd[i]} !== 3'b000) begin
                bad++; $display("FAIL reset_pulses dut%0d got %b want 000", i, {moved[i], bump[i], map_rd[i]});
            end
        end
    endtask

    // One press of key k held for 'hold' cycles; every instance is compared
    // with the model on position, count and the number of each pulse.
    task automatic test_press(input logic [3:0] k, input int hold, input string tag);
        int mv0 [4];
        int bp0 [4];
        int rd0 [4];
        int d;
        logic [7:0] exp_a;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mv0[i] = n_mv[i]; bp0[i] = n_bp[i]; rd0[i] = n_rd[i];
            e_mv[i] = 0; e_bp[i] = 0; e_rd[i] = 0;
        end
        d = key_dir(k);
        if (d >= 0) begin
            for (int i = 0; i < 4; i++) model_attempt(i, d);
        end
        key = k; en = 1'b1;
        repeat (hold) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_a = 8'(ex[i] * 16 + ey[i]);
            total++;
            if (addr[i] !== exp_a) begin
                bad++; $display("FAIL %s addr dut%0d got %h want %h", tag, i, addr[i], exp_a);
            end
            total++;
            if (cnt[i] !== 16'(ecnt[i])) begin
                bad++; $display("FAIL %s count dut%0d got %h want %h", tag, i, cnt[i], 16'(ecnt[i]));
            end
            total++;
            if (n_mv[i] - mv0[i] != e_mv[i]) begin
                bad++; $display("FAIL %s moved_pulses dut%0d got %0d want %0d", tag, i, n_mv[i] - mv0[i], e_mv[i]);
            end
            total++;
            if (n_bp[i] - bp0[i] != e_bp[i]) begin
                bad++; $display("FAIL %s bump_pulses dut%0d got %0d want %0d", tag, i, n_bp[i] - bp0[i], e_bp[i]);
            end
            total++;
            if (n_rd[i] - rd0[i] != e_rd[i]) begin
                bad++; $display("FAIL %s map_rd_pulses dut%0d got %0d want %0d", tag, i, n_rd[i] - rd0[i], e_rd[i]);
            end
        end
    endtask

    // Cycle-exact check of a single right move on the default instance.
    task automatic test_single_move();
        logic [7:0] exp_a;
        do_reset();
        clear_walls();
        for (int i = 0; i < 4; i++) model_attempt(i, 2);
        key = 4'h6; en = 1'b1;              // N0
        repeat (2) @(negedge clk);          // N2: synced edge cycle
        total++;
        if (addr[0] !== 8'h77 || map_rd[0] !== 1'b0) begin
            bad++; $display("FAIL t0_state got addr=%h rd=%b want addr=77 rd=0", addr[0], map_rd[0]);
        end
        @(negedge clk);                     // N3: lookup
        total++;
        if (map_rd[0] !== 1'b1 || map_addr[0] !== 8'h87) begin
            bad++; $display("FAIL lookup got rd=%b maddr=%h want rd=1 maddr=87", map_rd[0], map_addr[0]);
        end
        @(negedge clk);                     // N4: eval
        total++;
        if (addr[0] !== 8'h77 || map_rd[0] !== 1'b0 || moved[0] !== 1'b0) begin
            bad++; $display("FAIL eval got addr=%h rd=%b mv=%b want 77/0/0", addr[0], map_rd[0], moved[0]);
        end
        @(negedge clk);                     // N5: new address
        for (int i = 0; i < 4; i++) begin
            total++;
            if (addr[i] !== 8'h87 || moved[i] !== 1'b1 || bump[i] !== 1'b0) begin
                bad++; $display("FAIL t3_move dut%0d got addr=%h mv=%b bp=%b want 87/1/0", i, addr[i], moved[i], bump[i]);
            end
        end
        total++;
        if (cnt[0] !== 16'd1) begin
            bad++; $display("FAIL t3_count got %h want 0001", cnt[0]);
        end
        @(negedge clk);
        total++;
        if (moved[0] !== 1'b0 || map_addr[0] !== 8'h87) begin
            bad++; $display("FAIL moved_width got mv=%b maddr=%h want 0/87", moved[0], map_addr[0]);
        end
        en = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_a = 8'(ex[i] * 16 + ey[i]);
            total++;
            if (addr[i] !== exp_a || cnt[i] !== 16'(ecnt[i])) begin
                bad++; $display("FAIL single_final dut%0d got %h/%h want %h/%h", i, addr[i], cnt[i], exp_a, 16'(ecnt[i]));
            end
        end
    endtask

    task automatic test_edge();
        do_reset();
        clear_walls();
        for (int n = 0; n < 7; n++) test_press(4'h4, 2, "edge_walk_left");
        for (int n = 0; n < 2; n++) test_press(4'h2, 2, "edge_walk_up");
        test_press(4'h4, 3, "edge_left");
        total++;
        if (addr[0] !== 8'h05) begin
            bad++; $display("FAIL edge_nowrap got %h want 05", addr[0]);
        end
        total++;
        if (addr[1] !== 8'hF5) begin
            bad++; $display("FAIL edge_wrap got %h want f5", addr[1]);
        end
    endtask

    task automatic test_wall();
        do_reset();
        clear_walls();
        walls[8'h76] = 1'b1;
        test_press(4'h2, 3, "wall_up");
        total++;
        if (addr[0] !== 8'h77 || cnt[0] !== 16'd0) begin
            bad++; $display("FAIL wall_block got %h/%h want 77/0000", addr[0], cnt[0]);
        end
        test_press(4'h6, 3, "wall_then_right");
    endtask

    task automatic test_repeat();
        int t, t_first;
        int stamps [$];
        logic [7:0] exp_a;
        do_reset();
        clear_walls();
        for (int i = 0; i < 4; i++) model_attempt(i, 1);
        for (int n = 0; n < 4; n++) model_attempt(2, 1);
        key = 4'h8; en = 1'b1;
        t = 0; t_first = -1;
        while (t_first < 0 && t < 20) begin
            @(negedge clk); t++;
            if (moved[2] === 1'b1) t_first = t;
        end
        total++;
        if (t_first != 5) begin
            bad++; $display("FAIL repeat_first got cycle %0d want 5", t_first);
        end
        repeat (45) begin
            @(negedge clk); t++;
            if (moved[2] === 1'b1) stamps.push_back(t);
        end
        en = 1'b0;
        repeat (12) begin
            @(negedge clk); t++;
            if (moved[2] === 1'b1) stamps.push_back(t);
        end
        total++;
        if (stamps.size() != 4) begin
            bad++; $display("FAIL repeat_extra got %0d want 4", stamps.size());
        end
        for (int n = 0; n < stamps.size(); n++) begin
            total++;
            if (stamps[n] - (n == 0 ? t_first : stamps[n-1]) != 10) begin
                bad++; $display("FAIL repeat_spacing idx%0d got %0d want 10", n, stamps[n] - (n == 0 ? t_first : stamps[n-1]));
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_a = 8'(ex[i] * 16 + ey[i]);
            total++;
            if (addr[i] !== exp_a || cnt[i] !== 16'(ecnt[i])) begin
                bad++; $display("FAIL repeat_final dut%0d got %h/%h want %h/%h", i, addr[i], cnt[i], exp_a, 16'(ecnt[i]));
            end
        end
        total++;
        if (addr[2] !== 8'h7C || cnt[2] !== 16'hFFFF) begin
            bad++; $display("FAIL repeat_sat got %h/%h want 7c/ffff", addr[2], cnt[2]);
        end
        test_press(4'h8, 2, "after_release");
    endtask

    task automatic test_odd_grid();
        do_reset();
        clear_walls();
        for (int n = 0; n < 3; n++) test_press(4'h6, 2, "odd_right");
        total++;
        if (addr[3] !== 8'h07) begin
            bad++; $display("FAIL odd_wrap_x got %h want 07", addr[3]);
        end
        for (int n = 0; n < 8; n++) test_press(4'h2, 2, "odd_up");
        total++;
        if (addr[3] !== 8'h0B) begin
            bad++; $display("FAIL odd_wrap_y got %h want 0b", addr[3]);
        end
    endtask

    task automatic test_reset_mid_eval();
        do_reset();
        clear_walls();
        test_press(4'h8, 2, "pre_abort");
        @(negedge clk);
        key = 4'h6; en = 1'b1;
        repeat (4) @(negedge clk);          // now in EVAL
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (addr[i] !== 8'h77 || {moved[i], bump[i], map_rd[i]} !== 3'b000 || cnt[i] !== 16'(cfg_init[i])) begin
                bad++; $display("FAIL abort dut%0d got %h/%b/%h want 77/000/%h", i, addr[i],
                                {moved[i], bump[i], map_rd[i]}, cnt[i], 16'(cfg_init[i]));
            end
        end
        @(negedge clk); en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        total++;
        if (addr[0] !== 8'h77) begin
            bad++; $display("FAIL abort_late_move got %h want 77", addr[0]);
        end
        test_press(4'h6, 3, "post_abort");
    endtask

    task automatic test_random();
        logic [3:0] k;
        int r;
        do_reset();
        for (int a = 0; a < 256; a++) walls[a] = ($urandom_range(0, 4) == 0);
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: k = 4'h2;
                1: k = 4'h8;
                2: k = 4'h4;
                3: k = 4'h6;
                default: k = 4'($urandom_range(0, 15));
            endcase
            test_press(k, $urandom_range(1, 7), "random");
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; key = 4'h0;
        clear_walls();
        test_reset();
        test_single_move();
        test_edge();
        test_wall();
        test_repeat();
        test_odd_grid();
        test_reset_mid_eval();
        test_random();
        total++;
        if (n_both != 0) begin
            bad++; $display("FAIL moved_and_bump got %0d cycles want 0", n_both);
        end
        total++;
        if (n_range != 0) begin
            bad++; $display("FAIL odd_grid_range got %0d cycles want 0", n_range);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
